alu_mdu: RTL

Parametrised, handshaked successor to the combinational MIPS ALU. It executes the same 6-bit ALUFunc operation set (arith/logic/shift/compare) with one-cycle registered latency. It adds iterative multiply and divide that produce a double-width result, as needed for the HI/LO path of MULT/MULTU/DIV/DIVU. It sits in the EX stage, between operand forwarding and the EX/MEM register, and stalls the pipeline through its valid/ready handshake.

---
 rtl/alu_mdu.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// alu_mdu : handshaked EX-stage ALU with iterative double-width MUL/DIV
// Revision 1.0
// ============================================================================
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_op,
    input  logic [5:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0, S_MUL = 3'd1, S_DIV = 3'd2,
                           S_FIX  = 3'd3, S_DONE = 3'd4;

    localparam logic [5:0] F_ADD = 6'b000000, F_SUB = 6'b000001, F_AND = 6'b011000,
                           F_OR  = 6'b011110, F_XOR = 6'b010110, F_NOR = 6'b010001,
                           F_PASSA = 6'b011010, F_SLL = 6'b100000, F_SRL = 6'b100001,
                           F_SRA = 6'b100011, F_EQ  = 6'b110011, F_NEQ = 6'b110001,
                           F_LT  = 6'b110101, F_LEZ = 6'b111101, F_GEZ = 6'b111001,
                           F_GTZ = 6'b111111, F_MUL = 6'b000100, F_DIV = 6'b000110;

    logic [2:0]         state_q, state_d, launch_state;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   result_q, result_d, result_hi_q, result_hi_d;
    logic               overflow_q, overflow_d, div_zero_q, div_zero_d;

    logic               accept, is_mul, is_div, b_zero, a_neg, b_neg, simple_ovf;
    logic [WIDTH-1:0]   sum, diff, simple_res, abs_a, abs_b, src_m, quo, rem;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] src_p, step_p, prod_neg;
    logic               src_div;
    logic [WIDTH:0]     mul_sum, r_sh, r_diff;

    function automatic logic [WIDTH-1:0] flag(input logic f);
        return {{(WIDTH-1){1'b0}}, f};
    endfunction

    assign in_ready = rst_n && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum        = a + b;
        diff       = a - b;
        shamt      = a[SHW-1:0];
        simple_res = '0;
        simple_ovf = 1'b0;
        case (func)
            F_ADD: begin
                simple_res = sum;
                simple_ovf = signed_op && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            F_SUB: begin
                simple_res = diff;
                simple_ovf = signed_op && (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            F_AND:   simple_res = a & b;
            F_OR:    simple_res = a | b;
            F_XOR:   simple_res = a ^ b;
            F_NOR:   simple_res = ~(a | b);
            F_PASSA: simple_res = a;
            F_SLL:   simple_res = b << shamt;
            F_SRL:   simple_res = b >> shamt;
            F_SRA:   simple_res = $unsigned($signed(b) >>> shamt);
            F_EQ:    simple_res = flag(a == b);
            F_NEQ:   simple_res = flag(a != b);
            F_LT:    simple_res = flag(signed_op ? ($signed(a) < $signed(b)) : (a < b));
            F_LEZ:   simple_res = flag(a[WIDTH-1] || (a == '0));
            F_GEZ:   simple_res = flag(!a[WIDTH-1]);
            F_GTZ:   simple_res = flag(!a[WIDTH-1] && (a != '0));
            default: simple_res = '0;
        endcase
    end

    // Long ops run on magnitudes; the first iteration is folded into the accept edge.
    always_comb begin
        is_mul  = (func == F_MUL);
        is_div  = (func == F_DIV);
        b_zero  = (b == '0);
        a_neg   = signed_op && a[WIDTH-1];
        b_neg   = signed_op && b[WIDTH-1];
        abs_a   = a_neg ? -a : a;
        abs_b   = b_neg ? -b : b;
        src_p   = accept ? {{WIDTH{1'b0}}, abs_a} : p_q;
        src_m   = accept ? abs_b : m_q;
        src_div = accept ? is_div : div_q;
        mul_sum = {1'b0, src_p[2*WIDTH-1:WIDTH]} + ({1'b0, src_m} & {(WIDTH+1){src_p[0]}});
        r_sh    = src_p[2*WIDTH-1:WIDTH-1];
        r_diff  = r_sh - {1'b0, src_m};
        if (src_div) begin
            step_p = r_diff[WIDTH] ? {r_sh[WIDTH-1:0], src_p[WIDTH-2:0], 1'b0}
                                   : {r_diff[WIDTH-1:0], src_p[WIDTH-2:0], 1'b1};
        end else begin
            step_p = {mul_sum, src_p[WIDTH-1:1]};
        end
        prod_neg = -p_q;
        quo      = p_q[WIDTH-1:0];
        rem      = p_q[2*WIDTH-1:WIDTH];
        launch_state = is_mul ? S_MUL : ((is_div && !b_zero) ? S_DIV : S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            m_q         <= '0;
            div_q       <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            m_q         <= m_d;
            div_q       <= div_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            overflow_q  <= overflow_d;
            div_zero_q  <= div_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (accept) state_d = launch_state;
            S_MUL, S_DIV: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:        state_d = S_DONE;
            S_DONE: begin
                if (accept)         state_d = launch_state;
                else if (out_ready) state_d = S_IDLE;
            end
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        p_d         = p_q;
        m_d         = m_q;
        div_d       = div_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        overflow_d  = overflow_q;
        div_zero_d  = div_zero_q;
        if (accept) begin
            cnt_d       = CW'(WIDTH - 2);
            p_d         = step_p;
            m_d         = abs_b;
            div_d       = is_div;
            neg_lo_d    = a_neg ^ b_neg;
            neg_hi_d    = is_div && a_neg;
            result_d    = simple_res;
            result_hi_d = '0;
            overflow_d  = simple_ovf;
            div_zero_d  = 1'b0;
            if (is_div && b_zero) begin
                result_d    = '1;
                result_hi_d = a;
                div_zero_d  = 1'b1;
            end
        end else if (state_q == S_MUL || state_q == S_DIV) begin
            p_d   = step_p;
            cnt_d = cnt_q - 1'b1;
        end else if (state_q == S_FIX) begin
            if (div_q) begin
                result_d    = neg_lo_q ? -quo : quo;
                result_hi_d = neg_hi_q ? -rem : rem;
            end else begin
                {result_hi_d, result_d} = neg_lo_q ? prod_neg : p_q;
            end
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;
endmodule
`default_nettype wire
